// File: rtl/fpga_ram_pkg.sv
// Shared types and helpers for the streaming simple-dual-port RAM.
package fpga_ram_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } collision_e;

  function automatic logic [7:0] merge_be(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/fpga_sdp_ram_array.sv
// Inferable byte-enable simple-dual-port array: one write port, one registered read port.
module fpga_sdp_ram_array #(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 1024,
  parameter     INIT_FILE = "",
  localparam int NUM_BYTES = RAM_WIDTH / 8,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [NUM_BYTES-1:0] wr_be_i,
  input  logic [RAM_WIDTH-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [RAM_WIDTH-1:0] rd_data_o
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_data_q;
  logic                 wr_ok;
  logic                 rd_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_ok = {1'b0, rd_addr_i} < DEPTH_L;

  // Power-up image: the FPGA bitstream initialises the block RAM contents.
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end

  // NOTE: the array and its read register have no reset so they map onto block RAM primitives.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    if (rd_en_i) rd_data_q <= rd_ok ? mem[rd_addr_i] : '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fpga_sdp_ram_stream.sv
// SDP RAM with valid/ready read request/response channels; credit counter plus a
// fall-through response FIFO guarantee no read data is lost under backpressure.
module fpga_sdp_ram_stream
  import fpga_ram_pkg::*;
#(
  parameter int         RAM_WIDTH  = 64,
  parameter int         RAM_DEPTH  = 1024,
  parameter int         RD_LATENCY = 2,
  parameter collision_e COLLISION  = READ_FIRST,
  parameter             INIT_FILE  = "",
  localparam int NUM_BYTES = RAM_WIDTH / 8,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_BYTES-1:0] wr_be,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [AW-1:0]        rd_req_addr,
  output logic                 rd_rsp_valid,
  input  logic                 rd_rsp_ready,
  output logic [RAM_WIDTH-1:0] rd_rsp_data
);

  localparam int RSP_DEPTH = RD_LATENCY + 1;
  localparam int PW        = $clog2(RSP_DEPTH);
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  logic                  run_q;
  logic [CW-1:0]         out_q, out_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RAM_WIDTH-1:0]  fifo_mem [RSP_DEPTH];

  logic                 accept, pop, push, fifo_pop, fifo_empty, last_vld;
  logic [RAM_WIDTH-1:0] ram_rd_data, s1_data, last_data, rsp_sel;

  // Ready is derived from registered state only, so there is no path from the response side.
  assign rd_req_ready = run_q && (out_q < CW'(RSP_DEPTH));
  assign accept       = rd_req_valid && rd_req_ready;

  fpga_sdp_ram_array #(
    .RAM_WIDTH(RAM_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_be_i  (wr_be),
    .wr_data_i(wr_data),
    .rd_en_i  (accept),
    .rd_addr_i(rd_req_addr),
    .rd_data_o(ram_rd_data)
  );

  if (COLLISION == WRITE_FIRST) begin : g_write_first
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(RAM_DEPTH);
    logic                 fwd_q;
    logic [NUM_BYTES-1:0] fwd_be_q;
    logic [RAM_WIDTH-1:0] fwd_data_q;

    always_ff @(posedge clk) begin
      if (accept) begin
        fwd_q      <= wr_en && (wr_addr == rd_req_addr) && ({1'b0, wr_addr} < DEPTH_L);
        fwd_be_q   <= wr_be;
        fwd_data_q <= wr_data;
      end
    end

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
      s1_data = ram_rd_data;
      for (int b = 0; b < NUM_BYTES; b++) begin
        s1_data[8*b +: 8] = merge_be(ram_rd_data[8*b +: 8], fwd_data_q[8*b +: 8],
                                     fwd_q && fwd_be_q[b]);
      end
    end
  end else begin : g_read_first
    assign s1_data = ram_rd_data;
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  assign last_vld = vld_q[RD_LATENCY-1];

  if (RD_LATENCY == 1) begin : g_no_pipe
    assign last_data = s1_data;
  end else begin : g_pipe
    logic [RAM_WIDTH-1:0] dpipe_q [RD_LATENCY-1];

    always_ff @(posedge clk) begin
      dpipe_q[0] <= s1_data;
      for (int i = 1; i < RD_LATENCY - 1; i++) dpipe_q[i] <= dpipe_q[i-1];
    end

    assign last_data = dpipe_q[RD_LATENCY-2];
  end

  // Fall-through head: an empty FIFO presents the last pipeline stage directly.
  assign fifo_empty   = (cnt_q == '0);
  assign rd_rsp_valid = !fifo_empty || last_vld;
  assign rsp_sel      = fifo_empty ? last_data : fifo_mem[rd_ptr_q];
  assign rd_rsp_data  = rd_rsp_valid ? rsp_sel : '0;
  assign pop          = rd_rsp_valid && rd_rsp_ready;
  assign push         = last_vld && !(fifo_empty && rd_rsp_ready);
  assign fifo_pop     = pop && !fifo_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    case ({push, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      out_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      run_q    <= 1'b1;
      out_q    <= out_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= last_data;
  end

  a_out_max: assert property (@(posedge clk) disable iff (rst) out_q <= CW'(RSP_DEPTH));
  a_out_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> (out_q != '0));
  a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
                                    (push && !fifo_pop) |-> (cnt_q < CW'(RSP_DEPTH)));

endmodule
